// File: rtl/decodificador_pwm_servo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decodificador_pwm_servo_pkg
// Description : Shared types and default timing constants for the servo PWM
//               decoder (state encoding, nominal widths, tolerances, codes).
// Revision    : 1.0 - initial release
// ============================================================================
package decodificador_pwm_servo_pkg;

    // Decoder FSM states; the encoding is exported on db_estado
    typedef enum logic [1:0] {
        ESPERA     = 2'b00,
        MEDE_ALTO  = 2'b01,
        MEDE_BAIXO = 2'b10
    } estado_t;

    // Default timing at 50 MHz, in clock cycles
    localparam int C_CONF_PERIODO       = 1000000;
    localparam int C_LARGURA_0          = 28000;
    localparam int C_LARGURA_1          = 68300;
    localparam int C_LARGURA_2          = 114300;
    localparam int C_TOLERANCIA         = 2000;
    localparam int C_TOLERANCIA_PERIODO = 20000;

    // Position codes; 11 marks "no window matched" and never reaches posicao
    localparam logic [1:0] C_POSICAO_0        = 2'b00;
    localparam logic [1:0] C_POSICAO_1        = 2'b01;
    localparam logic [1:0] C_POSICAO_2        = 2'b10;
    localparam logic [1:0] C_POSICAO_INVALIDA = 2'b11;

    // Lower edge of an acceptance window, clamped at zero
    function automatic int limite_inferior(input int centro, input int tol);
        return (centro > tol) ? (centro - tol) : 0;
    endfunction

    // Two inclusive windows of half-width tol overlap when centres are <= 2*tol apart
    function automatic logic janelas_sobrepostas(input int a, input int b, input int tol);
        int d;
        d = (a > b) ? (a - b) : (b - a);
        return (d <= 2 * tol);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decodificador_pwm_servo_detector_borda.sv
`default_nettype none
// ============================================================================
// Module      : detector_borda
// Description : Two-flop synchronizer for the asynchronous PWM input plus a
//               registered copy for edge detection. Edge pulses are
//               registered, adding one stage so that both edges see the same
//               latency and the measured widths carry no offset.
// Revision    : 1.0 - initial release
// ============================================================================
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic sinal_sinc,
    output logic subida,
    output logic descida
);

    logic sinc1_q;
    logic sinc2_q;
    logic anterior_q;
    logic subida_q;
    logic descida_q;

    // Synchronize, keep the previous value and register one-cycle edge pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            sinc1_q    <= 1'b0;
            sinc2_q    <= 1'b0;
            anterior_q <= 1'b0;
            subida_q   <= 1'b0;
            descida_q  <= 1'b0;
        end else begin
            sinc1_q    <= entrada;
            sinc2_q    <= sinc1_q;
            anterior_q <= sinc2_q;
            subida_q   <= sinc2_q & ~anterior_q;
            descida_q  <= ~sinc2_q & anterior_q;
        end
    end

    assign sinal_sinc = sinc2_q;
    assign subida     = subida_q;
    assign descida    = descida_q;

endmodule
`default_nettype wire

// File: rtl/decodificador_pwm_servo.sv
`default_nettype none
// ============================================================================
// Module      : decodificador_pwm_servo
// Description : Measures high time and period of a servo PWM waveform and
//               recovers the 2-bit position code, with validity/error flags,
//               a one-cycle update strobe and a no-edge timeout.
//               Optional macro DECODIFICADOR_PWM_PERIODO_EN: also require the
//               measured period to lie within conf_periodo +/- tolerancia_periodo.
// Revision    : 1.0 - initial release
// ============================================================================
module decodificador_pwm_servo
    import decodificador_pwm_servo_pkg::*;
#(
    parameter int conf_periodo       = C_CONF_PERIODO,
    parameter int largura_0          = C_LARGURA_0,
    parameter int largura_1          = C_LARGURA_1,
    parameter int largura_2          = C_LARGURA_2,
    parameter int tolerancia         = C_TOLERANCIA,
    parameter int tolerancia_periodo = C_TOLERANCIA_PERIODO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pwm,
    output logic [1:0] posicao,
    output logic       valido,
    output logic       erro,
    output logic       pronto,
    output logic       db_pwm,
    output logic [1:0] db_posicao,
    output logic [1:0] db_estado
);

    localparam int             LIMITE_INT = 2 * conf_periodo;
    localparam int             W          = $clog2(LIMITE_INT + 1);
    localparam logic [W-1:0]   LIMITE     = W'(LIMITE_INT);
    localparam logic [W-1:0]   UM         = W'(1);

    localparam logic [W-1:0]   L0_MIN = W'(limite_inferior(largura_0, tolerancia));
    localparam logic [W-1:0]   L0_MAX = W'(largura_0 + tolerancia);
    localparam logic [W-1:0]   L1_MIN = W'(limite_inferior(largura_1, tolerancia));
    localparam logic [W-1:0]   L1_MAX = W'(largura_1 + tolerancia);
    localparam logic [W-1:0]   L2_MIN = W'(limite_inferior(largura_2, tolerancia));
    localparam logic [W-1:0]   L2_MAX = W'(largura_2 + tolerancia);

    // Overlapping windows would make the decoded code ambiguous
    if (janelas_sobrepostas(largura_0, largura_1, tolerancia) ||
        janelas_sobrepostas(largura_0, largura_2, tolerancia) ||
        janelas_sobrepostas(largura_1, largura_2, tolerancia)) begin : g_janelas_sobrepostas
        $error("decodificador_pwm_servo: acceptance windows of largura_0/1/2 overlap");
    end

    // The period window must stay inside the counter range (0, 2*conf_periodo]
    if ((tolerancia_periodo < 0) || (tolerancia_periodo >= conf_periodo)) begin : g_tolerancia_periodo_invalida
        $error("decodificador_pwm_servo: tolerancia_periodo must be in [0, conf_periodo)");
    end

    logic         sinal_sinc;
    logic         subida;
    logic         descida;

    estado_t      estado_q;
    logic [W-1:0] largura_q;
    logic [W-1:0] periodo_q;
    logic [1:0]   posicao_q;
    logic         valido_q;
    logic         erro_q;
    logic         pronto_q;
    logic         timeout_feito_q;

    logic [W-1:0] largura_d;
    logic [W-1:0] periodo_d;
    logic         janela_0;
    logic         janela_1;
    logic         janela_2;
    logic         periodo_ok;
    logic         medida_valida;
    logic [1:0]   posicao_medida;
    logic         timeout;

    detector_borda u_detector_borda (
        .clock      (clock),
        .reset      (reset),
        .entrada    (pwm),
        .sinal_sinc (sinal_sinc),
        .subida     (subida),
        .descida    (descida)
    );

    // Saturating increments of both counters
    assign largura_d = (largura_q == LIMITE) ? LIMITE : (largura_q + UM);
    assign periodo_d = (periodo_q == LIMITE) ? LIMITE : (periodo_q + UM);

    assign janela_0 = (largura_q >= L0_MIN) && (largura_q <= L0_MAX);
    assign janela_1 = (largura_q >= L1_MIN) && (largura_q <= L1_MAX);
    assign janela_2 = (largura_q >= L2_MIN) && (largura_q <= L2_MAX);

`ifdef DECODIFICADOR_PWM_PERIODO_EN
    localparam logic [W-1:0] P_MIN = W'(conf_periodo - tolerancia_periodo);
    localparam logic [W-1:0] P_MAX = W'(conf_periodo + tolerancia_periodo);
    assign periodo_ok = (periodo_q >= P_MIN) && (periodo_q <= P_MAX);
`else
    assign periodo_ok = 1'b1;
`endif

    assign medida_valida = (janela_0 | janela_1 | janela_2) & periodo_ok;

    // Map the matching window to its code; 11 when none matched
    always_comb begin
        posicao_medida = C_POSICAO_INVALIDA;
        if (janela_0) begin
            posicao_medida = C_POSICAO_0;
        end else if (janela_1) begin
            posicao_medida = C_POSICAO_1;
        end else if (janela_2) begin
            posicao_medida = C_POSICAO_2;
        end
    end

    // Period counter at its ceiling fires once, unless a rise arrives the same
    // cycle (MEDE_ALTO cannot see a rise, so it only yields there for reset)
    assign timeout = (periodo_q == LIMITE) && !timeout_feito_q &&
                     !(subida && (estado_q != MEDE_ALTO));

    // Measurement FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q        <= ESPERA;
            largura_q       <= '0;
            periodo_q       <= '0;
            posicao_q       <= C_POSICAO_0;
            valido_q        <= 1'b0;
            erro_q          <= 1'b0;
            pronto_q        <= 1'b0;
            timeout_feito_q <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            if (timeout) begin
                valido_q        <= 1'b0;
                erro_q          <= 1'b1;
                pronto_q        <= 1'b1;
                timeout_feito_q <= 1'b1;
                estado_q        <= ESPERA;
            end else begin
                case (estado_q)
                    ESPERA: begin
                        if (subida) begin
                            largura_q       <= UM;
                            periodo_q       <= UM;
                            timeout_feito_q <= 1'b0;
                            estado_q        <= MEDE_ALTO;
                        end else begin
                            periodo_q <= periodo_d;
                        end
                    end
                    MEDE_ALTO: begin
                        periodo_q <= periodo_d;
                        if (descida) begin
                            estado_q <= MEDE_BAIXO;
                        end else begin
                            largura_q <= largura_d;
                        end
                    end
                    MEDE_BAIXO: begin
                        if (subida) begin
                            if (medida_valida) begin
                                posicao_q <= posicao_medida;
                                valido_q  <= 1'b1;
                                erro_q    <= 1'b0;
                            end else begin
                                valido_q  <= 1'b0;
                                erro_q    <= 1'b1;
                            end
                            pronto_q        <= 1'b1;
                            largura_q       <= UM;
                            periodo_q       <= UM;
                            timeout_feito_q <= 1'b0;
                            estado_q        <= MEDE_ALTO;
                        end else begin
                            periodo_q <= periodo_d;
                        end
                    end
                    default: begin
                        estado_q <= ESPERA;
                    end
                endcase
            end
        end
    end

    assign posicao    = posicao_q;
    assign valido     = valido_q;
    assign erro       = erro_q;
    assign pronto     = pronto_q;
    assign db_pwm     = sinal_sinc;
    assign db_posicao = posicao_q;
    assign db_estado  = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_decodificador_pwm_servo.sv
`default_nettype none
// ============================================================================
// Module      : tb_decodificador_pwm_servo
// Description : Self-checking bench for decodificador_pwm_servo with scaled
//               timing parameters and a behavioural decode model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decodificador_pwm_servo;

    localparam int P_CONF = 1000;
    localparam int L0     = 28;
    localparam int L1     = 68;
    localparam int L2     = 114;
    localparam int TOL    = 2;
    localparam int TOLP   = 20;
    localparam int LIMITE = 2 * P_CONF;

    logic       clock = 1'b0;
    logic       reset;
    logic       pwm;
    logic [1:0] posicao;
    logic       valido;
    logic       erro;
    logic       pronto;
    logic       db_pwm;
    logic [1:0] db_posicao;
    logic [1:0] db_estado;

    int testes = 0;
    int falhas = 0;

    // Reference model state: a measurement is open, previous pulse, held code
    logic       medindo = 1'b0;
    int         ant_h   = 0;
    int         ant_p   = 0;
    logic [1:0] exp_pos = 2'b00;

    always #10 clock = ~clock;

    decodificador_pwm_servo #(
        .conf_periodo       (P_CONF),
        .largura_0          (L0),
        .largura_1          (L1),
        .largura_2          (L2),
        .tolerancia         (TOL),
        .tolerancia_periodo (TOLP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pwm        (pwm),
        .posicao    (posicao),
        .valido     (valido),
        .erro       (erro),
        .pronto     (pronto),
        .db_pwm     (db_pwm),
        .db_posicao (db_posicao),
        .db_estado  (db_estado)
    );

    function automatic int abs_int(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Decode rule: high time within TOL of a nominal width (and period check if enabled)
    function automatic void classificar(input int h, input int p, output logic ok, output logic [1:0] pos);
        int larg [3];
        larg[0] = L0;
        larg[1] = L1;
        larg[2] = L2;
        ok  = 1'b0;
        pos = 2'b00;
        for (int i = 0; i < 3; i++) begin
            if (abs_int(h - larg[i]) <= TOL) begin
                ok  = 1'b1;
                pos = 2'(i);
            end
        end
        if (p <= 0) ok = 1'b0;
`ifdef DECODIFICADOR_PWM_PERIODO_EN
        if (abs_int(p - P_CONF) > TOLP) ok = 1'b0;
`endif
    endfunction

    // One PWM period: high h cycles, total p cycles. The rise terminates the
    // previous period, whose result must appear 4 samples later; a period
    // longer than LIMITE must produce exactly one timeout strobe.
    task automatic gerar_pulso(input int h, input int p);
        logic       ok;
        logic [1:0] pos_calc;
        logic       esp_pronto;
        logic       esp_val;
        logic       esp_err;
        logic       esp_timeout;
        int         n_inesperado;
        int         n_timeout;
        esp_pronto = medindo;
        esp_val    = 1'b0;
        esp_err    = 1'b0;
        if (medindo) begin
            classificar(ant_h, ant_p, ok, pos_calc);
            if (ok) exp_pos = pos_calc;
            esp_val = ok;
            esp_err = !ok;
        end
        esp_timeout  = (p > LIMITE);
        n_inesperado = 0;
        n_timeout    = 0;
        pwm = 1'b1;
        for (int c = 1; c <= p; c++) begin
            @(posedge clock);
            #1;
            if (c == h) pwm = 1'b0;
            if (c == 4) begin
                testes++;
                if (pronto !== esp_pronto) begin
                    falhas++;
                    $display("FAIL pronto_latencia: got %b expected %b (h=%0d p=%0d)", pronto, esp_pronto, ant_h, ant_p);
                end
                testes++;
                if (db_estado !== 2'b01) begin
                    falhas++;
                    $display("FAIL estado_apos_subida: got %b expected 01", db_estado);
                end
                if (h >= 4) begin
                    testes++;
                    if (db_pwm !== 1'b1) begin
                        falhas++;
                        $display("FAIL db_pwm: got %b expected 1", db_pwm);
                    end
                end
                if (esp_pronto) begin
                    testes++;
                    if ({posicao, db_posicao, valido, erro} !== {exp_pos, exp_pos, esp_val, esp_err}) begin
                        falhas++;
                        $display("FAIL decodificacao: got pos=%b dbpos=%b val=%b err=%b expected pos=%b val=%b err=%b (h=%0d p=%0d)",
                                 posicao, db_posicao, valido, erro, exp_pos, esp_val, esp_err, ant_h, ant_p);
                    end
                end
            end else if (pronto === 1'b1) begin
                if (esp_timeout && (c >= LIMITE + 2) && (c <= LIMITE + 5) && (n_timeout == 0)) begin
                    n_timeout++;
                    testes++;
                    if ({posicao, valido, erro, db_estado} !== {exp_pos, 1'b0, 1'b1, 2'b00}) begin
                        falhas++;
                        $display("FAIL timeout_saidas: got pos=%b val=%b err=%b est=%b expected pos=%b val=0 err=1 est=00",
                                 posicao, valido, erro, db_estado, exp_pos);
                    end
                end else begin
                    n_inesperado++;
                end
            end
        end
        testes++;
        if (n_inesperado != 0) begin
            falhas++;
            $display("FAIL pronto_inesperado: got %0d extra pulses expected 0 (h=%0d p=%0d)", n_inesperado, h, p);
        end
        if (esp_timeout) begin
            testes++;
            if (n_timeout != 1) begin
                falhas++;
                $display("FAIL timeout_pulsos: got %0d expected 1 (h=%0d p=%0d)", n_timeout, h, p);
            end
        end
        medindo = !esp_timeout;
        ant_h   = h;
        ant_p   = p;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        pwm   = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        testes++;
        if ({posicao, valido, erro, pronto, db_estado, db_pwm, db_posicao} !== 9'b0) begin
            falhas++;
            $display("FAIL reset_valores: got pos=%b val=%b err=%b pr=%b est=%b dbpwm=%b dbpos=%b expected all 0",
                     posicao, valido, erro, pronto, db_estado, db_pwm, db_posicao);
        end
        reset   = 1'b0;
        medindo = 1'b0;
        exp_pos = 2'b00;
    endtask

    task automatic test_nominal_01;
        repeat (3) gerar_pulso(L1, P_CONF);
    endtask

    task automatic test_tolerancia;
        gerar_pulso(L0 + TOL, P_CONF);
        gerar_pulso(L0 + TOL + 1, P_CONF);
        gerar_pulso(L0 - TOL, P_CONF);
    endtask

    task automatic test_nominal_10;
        gerar_pulso(L2, P_CONF);
        gerar_pulso(L2 - TOL, P_CONF);
        gerar_pulso(L2 + TOL, P_CONF);
    endtask

    task automatic test_periodo;
        gerar_pulso(L1, 900);
        gerar_pulso(L1, P_CONF + TOLP);
        gerar_pulso(L1, P_CONF - TOLP - 1);
        gerar_pulso(L0, P_CONF);
    endtask

    task automatic test_timeout_baixo;
        gerar_pulso(L1, P_CONF);
        gerar_pulso(L1, LIMITE + 200);
        gerar_pulso(L1, P_CONF);
    endtask

    task automatic test_timeout_alto;
        gerar_pulso(L2, P_CONF);
        gerar_pulso(LIMITE + 200, LIMITE + 230);
        gerar_pulso(L0, P_CONF);
    endtask

    task automatic test_reset_meio;
        int n;
        gerar_pulso(L2, P_CONF);
        pwm = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        pwm   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        testes++;
        if ({posicao, valido, erro, pronto, db_estado} !== 7'b0) begin
            falhas++;
            $display("FAIL reset_meio: got pos=%b val=%b err=%b pr=%b est=%b expected all 0",
                     posicao, valido, erro, pronto, db_estado);
        end
        reset   = 1'b0;
        medindo = 1'b0;
        exp_pos = 2'b00;
        n = 0;
        for (int c = 0; c < 900; c++) begin
            @(posedge clock);
            #1;
            if (pronto === 1'b1) n++;
        end
        testes++;
        if (n != 0) begin
            falhas++;
            $display("FAIL reset_meio_pronto: got %0d pulses expected 0", n);
        end
        gerar_pulso(L1, P_CONF);
        gerar_pulso(L0, P_CONF);
    endtask

    task automatic test_aleatorio;
        int larg [3];
        int h;
        int p;
        int cod;
        larg[0] = L0;
        larg[1] = L1;
        larg[2] = L2;
        for (int k = 0; k < 16; k++) begin
            cod = int'($urandom_range(0, 2));
            h   = larg[cod] + int'($urandom_range(0, 8)) - 4;
            if ($urandom_range(0, 4) == 0) h = int'($urandom_range(5, 200));
            p   = P_CONF + int'($urandom_range(0, 80)) - 40;
            gerar_pulso(h, p);
        end
    endtask

    initial begin
        reset = 1'b1;
        pwm   = 1'b0;
        test_reset();
        test_nominal_01();
        test_tolerancia();
        test_nominal_10();
        test_periodo();
        test_timeout_baixo();
        test_timeout_alto();
        test_reset_meio();
        test_aleatorio();
        gerar_pulso(L1, P_CONF);
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decodificador_pwm_servo.md
# decodificador_pwm_servo

Measures a servo-style PWM waveform and recovers the 2-bit position code that produced it, the receive-side counterpart of the base servo PWM generator. Sits on the feedback/loopback path of the servo subsystem: it checks the generated `controle` waveform in-system and gives the controller a decoded position plus a validity flag. Assumes a 50 MHz clock (20 ns/cycle), so all parameters are in clock cycles.

## Interface
- `conf_periodo`, 1000000: nominal PWM period in cycles (20 ms).
- `largura_0`, 28000: nominal high time for code 00.
- `largura_1`, 68300: nominal high time for code 01.
- `largura_2`, 114300: nominal high time for code 10.
- `tolerancia`, 2000: accepted ± deviation of high time, inclusive.
- `tolerancia_periodo`, 20000: accepted ± deviation of period, inclusive. Used only with the period-check macro.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pwm` in 1: asynchronous PWM input.
- `posicao` out 2: last decoded position code.
- `valido` out 1: high while the last completed period decoded successfully.
- `erro` out 1: high while the last completed period, or a timeout, failed decoding.
- `pronto` out 1: one-cycle pulse when `posicao`/`valido`/`erro` are updated.
- `db_pwm` out 1: synchronized `pwm`.
- `db_posicao` out 2: copy of `posicao`.
- `db_estado` out 2: FSM state encoding.

## Operation
- `pwm` passes through a 2-flop synchronizer. Rise and fall edges are detected on the synchronized signal against a registered copy.
- The counters are `largura` (high cycles) and `periodo` (cycles since the last rise). Both are W = $clog2(2*conf_periodo+1) bits wide and saturate at 2*conf_periodo.
- **ESPERA (00):** waits for a rise.
  - Rise: both counters load 1, go to MEDE_ALTO.
  - No rise for 2*conf_periodo cycles: timeout. Fires once; the counter saturates until the next rise.
- **MEDE_ALTO (01):** both counters increment each cycle.
  - Fall: freeze `largura`, go to MEDE_BAIXO.
- **MEDE_BAIXO (10):** `periodo` increments.
  - Rise: the period is complete. Classify, pulse `pronto`, reload both counters to 1, go to MEDE_ALTO.
- **Classification:**
  - If |largura − largura_i| ≤ tolerancia for some i: `posicao`=i, `valido`=1, `erro`=0.
  - Otherwise: `valido`=0, `erro`=1, `posicao` holds its previous value.
  - Code 11 is never produced.
  - Parameter rule: the windows must not overlap. Check this with an elaboration-time assertion.
- **Timeout:**
  - Trigger: `periodo` reaches 2*conf_periodo in any state, including a stuck-high input in MEDE_ALTO.
  - Response: `valido`=0, `erro`=1, `pronto` pulses, `posicao` holds, state goes to ESPERA.
- The first rise after reset only starts a measurement. No `pronto` occurs until the next rise.

## Timing
- Reset values: `posicao`=00, `valido`=0, `erro`=0, `pronto`=0, `db_estado`=ESPERA. Counters and the synchronizer are cleared to 0.
- `reset` mid-measurement discards the partial period. Edge-detect history is cleared, so a `pwm` already high after reset counts as a rise.
- Latency: `pronto` rises exactly 3 cycles after the first clock edge that samples the terminating `pwm` rise. The outputs change in that same cycle and are stable until the next `pronto`.
- `largura` equals the exact number of input high cycles, with no ±1 offset from synchronization.
- A rise in the same cycle as the timeout threshold is treated as a rise; the timeout does not fire.

## Configuration
- `DECODIFICADOR_PWM_PERIODO_EN` defined:
  - Classification also requires |periodo − conf_periodo| ≤ tolerancia_periodo.
  - A period outside that window gives `erro`=1, `valido`=0.
- Undefined: the period is ignored and only the high time is classified. `tolerancia_periodo` is unused.

## Structure
- `decodificador_pwm_servo_pkg` holds:
  - the FSM state enum (ESPERA, MEDE_ALTO, MEDE_BAIXO);
  - the default timing constants (period, three widths, tolerances);
  - the code 11 "invalid" constant.
- Sub-module `detector_borda`: 2-flop synchronizer plus registered copy. Outputs `sinal_sinc`, `subida`, `descida`; synchronous reset.

## Test plan
- **Nominal 01:** reset, then 3 periods of 68300 high / 1000000 period → `pronto` at the 2nd and 3rd rises (+3 cycles), `posicao`=01, `valido`=1, `erro`=0.
- **Tolerance edge:** high 30000 → `posicao`=00, `valido`=1. Then high 30001 → `erro`=1, `valido`=0, `posicao` stays 00.
- **Nominal 10:** high 114300 → `posicao`=10. High 112300 and 116300 also → 10.
- **Timeout:**
  - `pwm` held low for 2000000 cycles after a valid period → one `pronto` pulse, `erro`=1, `valido`=0, state ESPERA, no further pulses.
  - Same for `pwm` held high.
- **Reset mid-high:** `reset` asserted 10000 cycles into a high phase → all outputs at reset values. The next rise produces no `pronto`; the following full period decodes correctly.
- **Period check:** high 68300, period 900000.
  - Macro defined → `erro`=1, `valido`=0.
  - Undefined → `posicao`=01, `valido`=1.
